rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Registered round-robin arbiter over `width` requesters.
- Produces a one-hot grant vector that feeds the one-hot-to-binary encoder stage directly downstream, which converts the grant into an index.
- Guarantees fairness via a rotating priority pointer and a bounded per-grant hold time.
- Single clock domain; synchronous active-low reset.

Parameters:
- width, 8, number of requesters; must be >= 2.
- MAX_HOLD, 4, maximum consecutive cycles one grant may be held; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req  input  width  per-requester request level; held high while a requester wants or holds the resource.
- gnt  output  width  registered grant; always one-hot or all-zero.
- gnt_vld  output  1  registered; high when gnt is non-zero.
- gnt_idx  output  $clog2(width)  registered binary index of the granted bit; present only with GNT_IDX_EN.

Behaviour:
- Reset (rst_n low at a clock edge):
  - gnt=0, gnt_vld=0, gnt_idx=0.
  - Internal pointer ptr=0, hold_cnt=0, state=IDLE.
  - Reset wins over any simultaneous req activity, including mid-grant.
- State IDLE:
  - If |req is low, stay in IDLE with outputs at zero.
  - If |req is high, select the first set bit of req searching circularly from ptr upward, wrapping width-1 -> 0.
  - Load gnt with that one-hot value, set gnt_vld=1, clear hold_cnt=0, go to BUSY.
  - Latency is 1 cycle: req sampled at edge E gives gnt valid after edge E.
- State BUSY, with current grant index g:
  - Hold: if req[g]=1 and hold_cnt < MAX_HOLD-1, keep gnt and increment hold_cnt. A grant is therefore visible for at most MAX_HOLD cycles.
  - End condition: req[g]=0 (release) or hold_cnt == MAX_HOLD-1 (expiry). On end:
    - Set ptr <= (g+1) mod width.
    - Run the circular search over the current req starting at g+1.
  - Handover: if the search finds a bit, grant it on the same edge (no idle bubble), clear hold_cnt, stay in BUSY.
  - If no bit is found: gnt=0, gnt_vld=0, go to IDLE.
  - Expiry with only req[g] set: the search wraps back to g, so g is regranted with no gap and hold_cnt restarts at 0.
- Requests on bits other than g have no effect during BUSY until the end condition.
- With MAX_HOLD=1, the grant rotates every cycle whenever more than one requester is active.
- ptr never changes except at end-of-grant or reset.
- hold_cnt width is $clog2(MAX_HOLD+1); it must never wrap.
- Invariants, checked every cycle:
  - $onehot0(gnt).
  - gnt_vld == |gnt.
  - gnt_vld=1 implies state=BUSY.
  - The granted requester had req=1 at the edge it was granted.

Optional Feature:
- Macro: GNT_IDX_EN.
- When defined:
  - The gnt_idx port and register exist.
  - gnt_idx is loaded with the binary index of the selected bit on the same edge gnt is loaded, so gnt_idx matches the encoder output with zero extra latency.
  - gnt_idx holds its last value when gnt goes to zero, and is 0 after reset.
- When undefined:
  - The gnt_idx port is absent and there is no index logic.
  - The index is obtained solely from the downstream encoder stage.

Test Plan (width=8, MAX_HOLD=4):
- Reset: rst_n low 2 cycles with req=8'hFF -> gnt=8'h00, gnt_vld=0 throughout. After release, first grant is gnt=8'h01 one cycle later (ptr=0).
- Single requester: req=8'h08 sampled at edge N -> gnt=8'h08, gnt_vld=1 after N. req dropped before edge N+2 -> gnt=8'h00, gnt_vld=0 after N+2.
- Full contention: req=8'hFF held 40 cycles -> gnt sequence 01,02,04,08,10,20,40,80,01, each held exactly 4 cycles, no idle cycles. Wrap from 80 to 01 is verified.
- Lone long holder: req=8'h20 held 12 cycles -> gnt=8'h20 continuously (regrant on each expiry), gnt_vld never drops.
- Handover and wrap: grant on 8'h02 with req=8'h82; drop bit1 -> next cycle gnt=8'h80. Then req=8'h01 and drop bit7 -> next cycle gnt=8'h01.
- Reset mid-grant: gnt=8'h10 at hold_cnt=2, assert rst_n low one edge -> gnt=8'h00. With req=8'hFF after reset, next grant is 8'h01 (ptr reset to 0). With GNT_IDX_EN, gnt_idx is 0 after reset and 4 during the 8'h10 grant.

Source files
------------

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - registered round-robin arbiter with bounded hold time (optional GNT_IDX_EN adds gnt_idx)
module rr_arbiter #(
    parameter int width    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [width-1:0]          req,
    output logic [width-1:0]          gnt,
    output logic                      gnt_vld
`ifdef GNT_IDX_EN
    ,
    output logic [$clog2(width)-1:0]  gnt_idx
`endif
);

    localparam int IW = $clog2(width);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [HW-1:0]   hold_cnt;

    logic [IW-1:0]   cur_idx;
    logic [IW-1:0]   next_start;
    logic [IW-1:0]   search_start;
    logic            found;
    logic [IW-1:0]   sel_idx;
    logic [width-1:0] sel_onehot;
    logic            hold_more;

    // Encode the current one-hot grant and pick the circular search start point
    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < width; i++) begin
            if (gnt[i]) cur_idx = i[IW-1:0];
        end
        next_start   = (cur_idx == IW'(width - 1)) ? '0 : cur_idx + 1'b1;
        search_start = (state == BUSY) ? next_start : ptr;
        hold_more    = req[cur_idx] && (hold_cnt < HW'(MAX_HOLD - 1));
    end

    // First set request bit at or after search_start, wrapping width-1 -> 0
    always_comb begin
        found      = 1'b0;
        sel_idx    = '0;
        for (int i = 0; i < width; i++) begin
            int j;
            j = int'(search_start) + i;
            if (j >= width) j = j - width;
            if (!found && req[j]) begin
                found   = 1'b1;
                sel_idx = j[IW-1:0];
            end
        end
        sel_onehot = {{(width-1){1'b0}}, 1'b1} << sel_idx;
    end

    // Grant FSM: IDLE picks from ptr, BUSY holds until release or expiry then hands over
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_vld  <= 1'b0;
`ifdef GNT_IDX_EN
            gnt_idx  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt      <= sel_onehot;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= '0;
                        state    <= BUSY;
`ifdef GNT_IDX_EN
                        gnt_idx  <= sel_idx;
`endif
                    end
                end
                BUSY: begin
                    if (hold_more) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        // End of grant: advance priority past the finished holder
                        ptr      <= next_start;
                        hold_cnt <= '0;
                        if (found) begin
                            gnt     <= sel_onehot;
                            gnt_vld <= 1'b1;
`ifdef GNT_IDX_EN
                            gnt_idx <= sel_idx;
`endif
                        end else begin
                            gnt     <= '0;
                            gnt_vld <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= '0;
                    gnt_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed self-checking bench for rr_arbiter
module tb_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       gnt_vld;
`ifdef GNT_IDX_EN
    logic [2:0] gnt_idx;
`endif

    int total = 0;
    int bad   = 0;
    bit mon_en = 0;

    rr_arbiter #(.width(8), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
`ifdef GNT_IDX_EN
        ,
        .gnt_idx (gnt_idx)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Invariants sampled on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (!$onehot0(gnt)) begin
                $display("FAIL inv_onehot0 gnt=%h", gnt);
                bad++;
            end
            total++;
            if (gnt_vld !== (|gnt)) begin
                $display("FAIL inv_vld gnt_vld=%b required=%b", gnt_vld, |gnt);
                bad++;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        cycle();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        req   = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++;
            if (gnt !== 8'h00 || gnt_vld !== 1'b0) begin
                $display("FAIL reset_hold gnt=%h vld=%b required 00/0", gnt, gnt_vld);
                bad++;
            end
        end
        rst_n = 1;
        cycle();
        total++;
        if (gnt !== 8'h01 || gnt_vld !== 1'b1) begin
            $display("FAIL reset_first_gnt gnt=%h vld=%b required 01/1", gnt, gnt_vld);
            bad++;
        end
`ifdef GNT_IDX_EN
        total++;
        if (gnt_idx !== 3'd0) begin
            $display("FAIL reset_first_idx got=%0d required=0", gnt_idx);
            bad++;
        end
`endif
        req = 8'h00;
        cycle();
        total++;
        if (gnt !== 8'h00 || gnt_vld !== 1'b0) begin
            $display("FAIL reset_release gnt=%h vld=%b required 00/0", gnt, gnt_vld);
            bad++;
        end
    endtask

    task automatic test_single();
        req = 8'h08;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++;
            if (gnt !== 8'h08 || gnt_vld !== 1'b1) begin
                $display("FAIL single_gnt cyc=%0d gnt=%h vld=%b required 08/1", i, gnt, gnt_vld);
                bad++;
            end
        end
        req = 8'h00;
        cycle();
        total++;
        if (gnt !== 8'h00 || gnt_vld !== 1'b0) begin
            $display("FAIL single_drop gnt=%h vld=%b required 00/0", gnt, gnt_vld);
            bad++;
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp;
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 40; k++) begin
            cycle();
            exp = 8'h01 << ((k / 4) % 8);
            total++;
            if (gnt !== exp || gnt_vld !== 1'b1) begin
                $display("FAIL contention cyc=%0d gnt=%h required=%h vld=%b", k, gnt, exp, gnt_vld);
                bad++;
            end
        end
        req = 8'h00;
        cycle();
        total++;
        if (gnt !== 8'h00) begin
            $display("FAIL contention_end gnt=%h required=00", gnt);
            bad++;
        end
    endtask

    task automatic test_lone_holder();
        req = 8'h20;
        for (int k = 0; k < 12; k++) begin
            cycle();
            total++;
            if (gnt !== 8'h20 || gnt_vld !== 1'b1) begin
                $display("FAIL lone cyc=%0d gnt=%h vld=%b required 20/1", k, gnt, gnt_vld);
                bad++;
            end
        end
        req = 8'h00;
        cycle();
        total++;
        if (gnt !== 8'h00 || gnt_vld !== 1'b0) begin
            $display("FAIL lone_end gnt=%h vld=%b required 00/0", gnt, gnt_vld);
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 8'h82;
        cycle();
        total++;
        if (gnt !== 8'h02) begin
            $display("FAIL handover_first gnt=%h required=02", gnt);
            bad++;
        end
        req = 8'h80;
        cycle();
        total++;
        if (gnt !== 8'h80 || gnt_vld !== 1'b1) begin
            $display("FAIL handover_to_7 gnt=%h vld=%b required 80/1", gnt, gnt_vld);
            bad++;
        end
`ifdef GNT_IDX_EN
        total++;
        if (gnt_idx !== 3'd7) begin
            $display("FAIL handover_idx7 got=%0d required=7", gnt_idx);
            bad++;
        end
`endif
        req = 8'h01;
        cycle();
        total++;
        if (gnt !== 8'h01 || gnt_vld !== 1'b1) begin
            $display("FAIL handover_wrap gnt=%h vld=%b required 01/1", gnt, gnt_vld);
            bad++;
        end
        req = 8'h00;
        cycle();
        total++;
        if (gnt !== 8'h00) begin
            $display("FAIL handover_end gnt=%h required=00", gnt);
            bad++;
        end
`ifdef GNT_IDX_EN
        total++;
        if (gnt_idx !== 3'd0) begin
            $display("FAIL idx_hold got=%0d required=0", gnt_idx);
            bad++;
        end
`endif
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'h10;
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++;
            if (gnt !== 8'h10) begin
                $display("FAIL midrst_hold cyc=%0d gnt=%h required=10", k, gnt);
                bad++;
            end
`ifdef GNT_IDX_EN
            total++;
            if (gnt_idx !== 3'd4) begin
                $display("FAIL midrst_idx got=%0d required=4", gnt_idx);
                bad++;
            end
`endif
        end
        req   = 8'hFF;
        rst_n = 0;
        cycle();
        total++;
        if (gnt !== 8'h00 || gnt_vld !== 1'b0) begin
            $display("FAIL midrst_clear gnt=%h vld=%b required 00/0", gnt, gnt_vld);
            bad++;
        end
`ifdef GNT_IDX_EN
        total++;
        if (gnt_idx !== 3'd0) begin
            $display("FAIL midrst_idx_clear got=%0d required=0", gnt_idx);
            bad++;
        end
`endif
        rst_n = 1;
        cycle();
        total++;
        if (gnt !== 8'h01 || gnt_vld !== 1'b1) begin
            $display("FAIL midrst_regrant gnt=%h vld=%b required 01/1", gnt, gnt_vld);
            bad++;
        end
        req = 8'h00;
        cycle();
    endtask

    initial begin
        rst_n = 0;
        req   = 8'h00;
        cycle();
        mon_en = 1;
        test_reset();
        test_single();
        test_contention();
        test_lone_holder();
        test_back_to_back();
        test_reset_mid_grant();
        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
